// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// The request, memory-status and arbiter-status codes are common to both caches and main memory.
package memory_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF   = 17;
  localparam int DATA_LEN_DEF     = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [1:0] MEM_INST_FINISHED = 2'd1;
  localparam logic [1:0] MEM_DATA_FINISHED = 2'd2;

  localparam logic [1:0] ARB_RESTING  = 2'd0;
  localparam logic [1:0] ARB_WAITING  = 2'd1;
  localparam logic [1:0] ARB_BUSY     = 2'd2;
  localparam logic [1:0] ARB_FINISHED = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/memory_arbiter.sv
// Shares the main-memory port between the I-cache and D-cache, one transaction at a time.
// Data side wins ties unless the instruction side has been passed over STARVE_LIMIT times in a row.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_LEN     = DATA_LEN_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            inst_vis_signal,
  input  logic [ADDR_WIDTH-1:0] inst_vis_addr,
  output logic [DATA_LEN-1:0]   inst_mem_data,
  output logic [1:0]            inst_mem_status,
  input  logic [1:0]            data_vis_signal,
  input  logic [ADDR_WIDTH-1:0] data_vis_addr,
  input  logic [DATA_LEN-1:0]   data_write_data,
  output logic [DATA_LEN-1:0]   data_mem_data,
  output logic [1:0]            data_mem_status,
  output logic [1:0]            mem_vis_signal,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [DATA_LEN-1:0]   mem_write_data,
  input  logic [DATA_LEN-1:0]   mem_data,
  input  logic [1:0]            mem_status
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  arb_state_e            state, state_next;
  logic [STREAK_W-1:0]   streak, streak_next;
  logic [1:0]            mem_vis_signal_next;
  logic [ADDR_WIDTH-1:0] mem_vis_addr_next;
  logic [DATA_LEN-1:0]   mem_write_data_next;
  logic [DATA_LEN-1:0]   inst_mem_data_next, data_mem_data_next;
  logic [1:0]            inst_mem_status_next, data_mem_status_next;
  logic                  inst_req, data_req;

  assign inst_req = (inst_vis_signal != MEM_NOP);
  assign data_req = (data_vis_signal != MEM_NOP);

  function automatic logic pick_inst(input logic i_req, input logic d_req, input logic starved);
    return i_req && (!d_req || starved);
  endfunction

  always_comb begin
    state_next           = state;
    streak_next          = streak;
    mem_vis_signal_next  = mem_vis_signal;
    mem_vis_addr_next    = mem_vis_addr;
    mem_write_data_next  = mem_write_data;
    inst_mem_data_next   = inst_mem_data;
    data_mem_data_next   = data_mem_data;
    inst_mem_status_next = inst_mem_status;
    data_mem_status_next = data_mem_status;

    case (state)
      IDLE: begin
        mem_vis_signal_next  = MEM_NOP;
        inst_mem_status_next = ARB_RESTING;
        data_mem_status_next = ARB_RESTING;
        if (inst_req || data_req) begin
          if (pick_inst(inst_req, data_req, streak == STREAK_MAX)) begin
            state_next           = GRANT_INST;
            mem_vis_signal_next  = MEM_READ;
            mem_vis_addr_next    = inst_vis_addr;
            streak_next          = '0;
            inst_mem_status_next = ARB_BUSY;
            data_mem_status_next = data_req ? ARB_WAITING : ARB_RESTING;
          end else begin
            state_next           = GRANT_DATA;
            mem_vis_signal_next  = (data_vis_signal == MEM_WRITE) ? MEM_WRITE : MEM_READ;
            mem_vis_addr_next    = data_vis_addr;
            mem_write_data_next  = data_write_data;
            data_mem_status_next = ARB_BUSY;
            inst_mem_status_next = inst_req ? ARB_WAITING : ARB_RESTING;
            // Streak only grows while the I-cache is actually being passed over.
            if (!inst_req)
              streak_next = '0;
            else if (streak != STREAK_MAX)
              streak_next = streak + STREAK_W'(1);
          end
        end
      end

      GRANT_INST: begin
        data_mem_status_next = data_req ? ARB_WAITING : ARB_RESTING;
        if (mem_status == MEM_INST_FINISHED) begin
          inst_mem_data_next   = mem_data;
          inst_mem_status_next = ARB_FINISHED;
          mem_vis_signal_next  = MEM_NOP;
          state_next           = IDLE;
        end else if (!inst_req) begin
          inst_mem_status_next = ARB_RESTING;
          mem_vis_signal_next  = MEM_NOP;
          state_next           = IDLE;
        end
      end

      GRANT_DATA: begin
        inst_mem_status_next = inst_req ? ARB_WAITING : ARB_RESTING;
        // A finish takes precedence over a same-cycle abort so returned data is never lost.
        if (mem_status == MEM_DATA_FINISHED) begin
          data_mem_data_next   = mem_data;
          data_mem_status_next = ARB_FINISHED;
          mem_vis_signal_next  = MEM_NOP;
          state_next           = IDLE;
        end else if (!data_req) begin
          data_mem_status_next = ARB_RESTING;
          mem_vis_signal_next  = MEM_NOP;
          state_next           = IDLE;
        end
      end

      default: begin
        state_next          = IDLE;
        mem_vis_signal_next = MEM_NOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      streak          <= '0;
      mem_vis_signal  <= MEM_NOP;
      mem_vis_addr    <= '0;
      mem_write_data  <= '0;
      inst_mem_data   <= '0;
      data_mem_data   <= '0;
      inst_mem_status <= ARB_RESTING;
      data_mem_status <= ARB_RESTING;
    end else begin
      state           <= state_next;
      streak          <= streak_next;
      mem_vis_signal  <= mem_vis_signal_next;
      mem_vis_addr    <= mem_vis_addr_next;
      mem_write_data  <= mem_write_data_next;
      inst_mem_data   <= inst_mem_data_next;
      data_mem_data   <= data_mem_data_next;
      inst_mem_status <= inst_mem_status_next;
      data_mem_status <= data_mem_status_next;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: bench plays both caches and main memory.
// Every forwarded finish is matched against a queue of expected completions.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam logic [AW-1:0] INST_ADDR = 17'h00100;
  localparam logic [AW-1:0] DATA_ADDR = 17'h00200;

  logic          clk;
  logic          rstn;
  logic [1:0]    inst_vis_signal;
  logic [AW-1:0] inst_vis_addr;
  logic [DW-1:0] inst_mem_data;
  logic [1:0]    inst_mem_status;
  logic [1:0]    data_vis_signal;
  logic [AW-1:0] data_vis_addr;
  logic [DW-1:0] data_write_data;
  logic [DW-1:0] data_mem_data;
  logic [1:0]    data_mem_status;
  logic [1:0]    mem_vis_signal;
  logic [AW-1:0] mem_vis_addr;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_data;
  logic [1:0]    mem_status;

  typedef struct packed {
    logic          is_inst;
    logic [DW-1:0] data;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  logic [DW-1:0] last_inst;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_LEN(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .inst_vis_signal(inst_vis_signal), .inst_vis_addr(inst_vis_addr),
    .inst_mem_data(inst_mem_data), .inst_mem_status(inst_mem_status),
    .data_vis_signal(data_vis_signal), .data_vis_addr(data_vis_addr),
    .data_write_data(data_write_data), .data_mem_data(data_mem_data),
    .data_mem_status(data_mem_status),
    .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
    .mem_write_data(mem_write_data), .mem_data(mem_data), .mem_status(mem_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] i_sig, input logic [AW-1:0] i_addr,
                                input logic [1:0] d_sig, input logic [AW-1:0] d_addr,
                                input logic [DW-1:0] d_wdata);
    inst_vis_signal = i_sig;
    inst_vis_addr   = i_addr;
    data_vis_signal = d_sig;
    data_vis_addr   = d_addr;
    data_write_data = d_wdata;
  endtask

  task automatic memory_finish(input logic is_inst, input logic [DW-1:0] word);
    mem_status = is_inst ? MEM_INST_FINISHED : MEM_DATA_FINISHED;
    mem_data   = word;
    sb.push_back('{is_inst: is_inst, data: word});
  endtask

  task automatic wait_grant(input string tag, output logic got_inst);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (mem_vis_signal === MEM_NOP && n < 6);
    check_output({tag, " issued"}, 64'(mem_vis_signal !== MEM_NOP), 64'd1);
    got_inst = (mem_vis_addr === INST_ADDR);
  endtask

  // Scoreboard side: every ARB_FINISHED must match the oldest expected completion.
  always @(negedge clk) begin
    if (inst_mem_status === ARB_FINISHED || data_mem_status === ARB_FINISHED) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_finish: observed inst=%0d data=%0d expected no finish",
               inst_mem_status, data_mem_status);
      end
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        if (inst_mem_status === ARB_FINISHED)
          check_output("sb_inst", {31'd0, 1'b1, inst_mem_data}, {31'd0, e.is_inst, e.data});
        else
          check_output("sb_data", {31'd0, 1'b0, data_mem_data}, {31'd0, e.is_inst, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic got_inst;
    logic [DW-1:0] word;

    // Reset with both caches requesting.
    rstn = 1'b0;
    mem_status = 2'd0;
    mem_data = '0;
    apply_stimulus(MEM_READ, INST_ADDR, MEM_READ, DATA_ADDR, 32'h0);
    tick(2);
    check_output("reset mem_vis_signal", 64'(mem_vis_signal), 64'(MEM_NOP));
    check_output("reset inst status", 64'(inst_mem_status), 64'(ARB_RESTING));
    check_output("reset data status", 64'(data_mem_status), 64'(ARB_RESTING));
    check_output("reset mem_vis_addr", 64'(mem_vis_addr), 64'd0);
    check_output("reset data out", 64'(data_mem_data), 64'd0);
    apply_stimulus(MEM_NOP, '0, MEM_NOP, '0, '0);
    rstn = 1'b1;
    tick();

    // Instruction-only read.
    apply_stimulus(MEM_READ, 17'h00010, MEM_NOP, '0, '0);
    tick();
    check_output("inst read signal", 64'(mem_vis_signal), 64'(MEM_READ));
    check_output("inst busy", 64'(inst_mem_status), 64'(ARB_BUSY));
    check_output("inst read data idle", 64'(data_mem_status), 64'(ARB_RESTING));
    for (int c = 0; c < 3; c++) begin
      check_output("inst addr held", 64'(mem_vis_addr), 64'h10);
      if (c < 2) tick();
    end
    memory_finish(1'b1, 32'h13000000);
    tick();
    check_output("inst finished", 64'(inst_mem_status), 64'(ARB_FINISHED));
    check_output("inst finish drops mem", 64'(mem_vis_signal), 64'(MEM_NOP));
    mem_status = 2'd0;
    apply_stimulus(MEM_NOP, '0, MEM_NOP, '0, '0);
    tick();
    check_output("inst finished one cycle", 64'(inst_mem_status), 64'(ARB_RESTING));
    last_inst = 32'h13000000;

    // Both request continuously: four data grants, then one inst grant, repeated.
    apply_stimulus(MEM_READ, INST_ADDR, MEM_READ, DATA_ADDR, '0);
    for (int k = 0; k < 10; k++) begin
      wait_grant($sformatf("grant%0d", k), got_inst);
      check_output($sformatf("grant%0d owner", k), 64'(got_inst), 64'(k % 5 == 4));
      if (k == 0)
        check_output("inst waiting", 64'(inst_mem_status), 64'(ARB_WAITING));
      word = 32'hA000_0000 + 32'(k);
      if (got_inst) last_inst = word;
      memory_finish(got_inst, word);
      tick();
      mem_status = 2'd0;
    end
    apply_stimulus(MEM_NOP, '0, MEM_NOP, '0, '0);
    tick(2);

    // Data write at top of memory with a stray instruction finish.
    apply_stimulus(MEM_NOP, '0, MEM_WRITE, 17'h1FFFC, 32'hDEADBEEF);
    tick();
    check_output("write signal", 64'(mem_vis_signal), 64'(MEM_WRITE));
    check_output("write data", 64'(mem_write_data), 64'hDEADBEEF);
    check_output("write addr", 64'(mem_vis_addr), 64'h1FFFC);
    mem_status = MEM_INST_FINISHED;
    mem_data = 32'h0BAD0BAD;
    tick();
    check_output("stray finish ignored", 64'(data_mem_status), 64'(ARB_BUSY));
    check_output("stray keeps write", 64'(mem_vis_signal), 64'(MEM_WRITE));
    check_output("inst data held", 64'(inst_mem_data), 64'(last_inst));
    memory_finish(1'b0, 32'h00000001);
    tick();
    check_output("write finished", 64'(data_mem_status), 64'(ARB_FINISHED));
    apply_stimulus(MEM_NOP, '0, MEM_NOP, '0, '0);
    mem_status = 2'd0;
    tick();

    // Instruction abort with data pending, then a late finish pulse.
    apply_stimulus(MEM_READ, 17'h00040, MEM_NOP, '0, '0);
    tick();
    check_output("abort inst busy", 64'(inst_mem_status), 64'(ARB_BUSY));
    apply_stimulus(MEM_READ, 17'h00040, MEM_READ, 17'h00080, '0);
    tick();
    check_output("abort data waiting", 64'(data_mem_status), 64'(ARB_WAITING));
    apply_stimulus(MEM_NOP, '0, MEM_READ, 17'h00080, '0);
    tick();
    check_output("abort drops mem", 64'(mem_vis_signal), 64'(MEM_NOP));
    check_output("abort inst resting", 64'(inst_mem_status), 64'(ARB_RESTING));
    mem_status = MEM_INST_FINISHED;
    mem_data = 32'h11111111;
    tick();
    check_output("post abort data grant", 64'(mem_vis_addr), 64'h80);
    check_output("post abort data busy", 64'(data_mem_status), 64'(ARB_BUSY));
    check_output("late finish discarded", 64'(inst_mem_data), 64'(last_inst));
    memory_finish(1'b0, 32'hCAFEF00D);
    tick();
    apply_stimulus(MEM_NOP, '0, MEM_NOP, '0, '0);
    mem_status = 2'd0;
    tick();
    check_output("data back to resting", 64'(data_mem_status), 64'(ARB_RESTING));

    // Reset in the middle of a data grant.
    apply_stimulus(MEM_NOP, '0, MEM_READ, DATA_ADDR, '0);
    tick();
    check_output("pre reset data busy", 64'(data_mem_status), 64'(ARB_BUSY));
    rstn = 1'b0;
    tick();
    check_output("mid reset mem nop", 64'(mem_vis_signal), 64'(MEM_NOP));
    check_output("mid reset data resting", 64'(data_mem_status), 64'(ARB_RESTING));
    rstn = 1'b1;
    apply_stimulus(MEM_NOP, '0, MEM_NOP, '0, '0);
    mem_status = MEM_DATA_FINISHED;
    mem_data = 32'h77777777;
    tick(2);
    check_output("no finish after reset", 64'(data_mem_status), 64'(ARB_RESTING));
    check_output("data out after reset", 64'(data_mem_data), 64'd0);
    mem_status = 2'd0;
    tick();

    check_output("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
